// File: rtl/ex_stage.sv
// Execute stage of the MIPS32 pipeline: combinational logic/shift unit plus a
// 32-iteration radix-2 restoring divider that writes HI/LO and stalls via ctrl.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

    state_t      state_q;
    logic [31:0] dvd_q;     // dividend, shifted out MSB-first; fills with quotient bits
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic [5:0]  cnt_q;
    logic        negq_q;
    logic        negr_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] logic_res;
    logic [31:0] shift_res;
    logic        is_div;
    logic        is_signed;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] rem_sh;
    logic        qbit_d;
    logic [32:0] rem_sub;
    logic [31:0] rem_d;
    logic        active;

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            OP_AND:  logic_res = reg1_i & reg2_i;
            OP_OR:   logic_res = reg1_i | reg2_i;
            OP_XOR:  logic_res = reg1_i ^ reg2_i;
            OP_NOR:  logic_res = ~(reg1_i | reg2_i);
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            OP_SLL:  shift_res = reg2_i << reg1_i[4:0];
            OP_SRL:  shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA:  shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default: shift_res = '0;
        endcase
    end

    assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_signed = (aluop_i == OP_DIV);
    assign a_neg     = is_signed && reg1_i[31];
    assign b_neg     = is_signed && reg2_i[31];
    assign abs_a     = a_neg ? (~reg1_i + 32'd1) : reg1_i;
    assign abs_b     = b_neg ? (~reg2_i + 32'd1) : reg2_i;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    assign rem_sh  = {rem_q, dvd_q[31]};
    assign qbit_d  = (rem_sh >= {1'b0, dvs_q});
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign rem_d   = qbit_d ? rem_sub[31:0] : rem_sh[31:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (annul_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_div) begin
                        if (reg2_i == 32'd0) begin
                            state_q <= S_DIVZERO;
                        end else begin
                            dvd_q   <= abs_a;
                            dvs_q   <= abs_b;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            negq_q  <= a_neg ^ b_neg;
                            negr_q  <= a_neg;
                            state_q <= S_ON;
                        end
                    end
                end
                S_DIVZERO: begin
                    hi_q    <= '0;
                    lo_q    <= '0;
                    state_q <= S_END;
                end
                S_ON: begin
                    if (cnt_q == LAST_ITER) begin
                        // Settle cycle: apply the signed fixup before END presents it.
                        lo_q    <= negq_q ? (~dvd_q + 32'd1) : dvd_q;
                        hi_q    <= negr_q ? (~rem_q + 32'd1) : rem_q;
                        state_q <= S_END;
                    end else begin
                        dvd_q <= {dvd_q[30:0], qbit_d};
                        rem_q <= rem_d;
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                S_END: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign active = !rst && !annul_i;

    always_comb begin
        wd_o       = rst ? 5'd0 : wd_i;
        wreg_o     = active && wreg_i && !is_div;
        wdata_o    = '0;
        if (!rst) begin
            if (alusel_i == SEL_LOGIC)      wdata_o = logic_res;
            else if (alusel_i == SEL_SHIFT) wdata_o = shift_res;
        end
        whilo_o    = active && (state_q == S_END);
        hi_o       = whilo_o ? hi_q : 32'd0;
        lo_o       = whilo_o ? lo_q : 32'd0;
        stallreq_o = active && (((state_q == S_IDLE) && is_div) ||
                                (state_q == S_DIVZERO) || (state_q == S_ON));
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table-driven ALU vectors, randomized ALU/divide checks
// against a plain-arithmetic model, and hand sequences for divider aborts.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] AND_ = 8'h24, OR_ = 8'h25, XOR_ = 8'h26, NOR_ = 8'h27;
    localparam logic [7:0] SLL_ = 8'h7C, SRL_ = 8'h02, SRA_ = 8'h03;
    localparam logic [7:0] DIV_ = 8'h1A, DIVU_ = 8'h1B, NOP_ = 8'h00;

    ex_stage dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [7:0] op, input logic [2:0] sel,
                                              input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        if (sel == 3'b001) begin
            if (op == AND_) return a & b;
            if (op == OR_)  return a | b;
            if (op == XOR_) return a ^ b;
            if (op == NOR_) return ~(a | b);
        end else if (sel == 3'b010) begin
            if (op == SLL_) return b * (32'd1 << sh);
            if (op == SRL_) return b / (32'd1 << sh);
            if (op == SRA_) return 32'(longint'($signed(b)) >>> sh);
        end
        return 32'd0;
    endfunction

    task automatic div_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = 0; r = 0;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        aluop_i = NOP_; alusel_i = 3'b000; reg1_i = 0; reg2_i = 0; wreg_i = 0; annul_i = 0;
    endtask

    // Called just after an edge; returns just after the edge ending END.
    task automatic do_div(input string name, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] q, r;
        int n;
        bit bad;
        div_model(sgn, a, b, q, r);
        aluop_i = sgn ? DIV_ : DIVU_; alusel_i = 3'b000;
        reg1_i = a; reg2_i = b; wreg_i = 1; wd_i = 5'd9; annul_i = 0;
        n = 0; bad = 0;
        @(negedge clk);
        while (!whilo_o && n < 40) begin
            if (!stallreq_o || wreg_o || hi_o != 0 || lo_o != 0) bad = 1;
            n++;
            if (n == 3) begin reg1_i = $urandom; reg2_i = $urandom; end
            @(posedge clk);
            @(negedge clk);
        end
        chk({name, " stall_cycles"}, n, (b == 0) ? 32'd2 : 32'd34);
        chk({name, " stall_phase_ok"}, {31'd0, bad}, 0);
        chk({name, " whilo"}, {31'd0, whilo_o}, 1);
        chk({name, " end_stall"}, {31'd0, stallreq_o}, 0);
        chk({name, " end_wreg"}, {31'd0, wreg_o}, 0);
        chk({name, " lo"}, lo_o, q);
        chk({name, " hi"}, hi_o, r);
        step();
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{OR_,  3'b001, 32'h0000_1100, 32'h0000_0020, 5'd5,  32'h0000_1120};
        vecs[1]  = '{SRA_, 3'b010, 32'd4,         32'h8000_0000, 5'd1,  32'hF800_0000};
        vecs[2]  = '{SRL_, 3'b010, 32'd4,         32'h8000_0000, 5'd2,  32'h0800_0000};
        vecs[3]  = '{SRA_, 3'b010, 32'h24,        32'h8000_0000, 5'd3,  32'hF800_0000};
        vecs[4]  = '{AND_, 3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd4,  32'h00F0_00F0};
        vecs[5]  = '{XOR_, 3'b001, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd6,  32'hF0F0_0F0F};
        vecs[6]  = '{NOR_, 3'b001, 32'h0000_FFFF, 32'h00FF_0000, 5'd7,  32'hFF00_0000};
        vecs[7]  = '{SLL_, 3'b010, 32'd8,         32'h1234_5678, 5'd8,  32'h3456_7800};
        vecs[8]  = '{SLL_, 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[9]  = '{NOP_, 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000};
        vecs[10] = '{OR_,  3'b000, 32'h1234_5678, 32'h0000_0001, 5'd11, 32'h0000_0000};
        vecs[11] = '{SRL_, 3'b010, 32'd0,         32'hDEAD_BEEF, 5'd12, 32'hDEAD_BEEF};

        aluop_i = OR_; alusel_i = 3'b001; reg1_i = 32'hFFFF_FFFF; reg2_i = 32'h1;
        wd_i = 5'd17; wreg_i = 1; annul_i = 0; rst = 1;
        step(); step();
        @(negedge clk);
        chk("rst wdata", wdata_o, 0);
        chk("rst wreg", {31'd0, wreg_o}, 0);
        chk("rst wd", {27'd0, wd_o}, 0);
        chk("rst stall", {31'd0, stallreq_o}, 0);
        chk("rst whilo", {31'd0, whilo_o}, 0);
        step();
        rst = 0;
        set_nop();
        step();

        for (int i = 0; i < 12; i++) begin
            aluop_i = vecs[i].op; alusel_i = vecs[i].sel; reg1_i = vecs[i].r1;
            reg2_i = vecs[i].r2; wd_i = vecs[i].wd; wreg_i = 1;
            #2;
            chk($sformatf("vec%0d wdata", i), wdata_o, vecs[i].exp);
            chk($sformatf("vec%0d wd", i), {27'd0, wd_o}, {27'd0, vecs[i].wd});
            chk($sformatf("vec%0d wreg", i), {31'd0, wreg_o}, 1);
            chk($sformatf("vec%0d stall", i), {31'd0, stallreq_o}, 0);
            step();
        end

        for (int i = 0; i < 150; i++) begin
            logic [7:0] ops[8];
            ops = '{AND_, OR_, XOR_, NOR_, SLL_, SRL_, SRA_, 8'h55};
            aluop_i = ops[$urandom_range(0, 7)];
            alusel_i = 3'($urandom_range(0, 3));
            reg1_i = $urandom; reg2_i = $urandom;
            wd_i = 5'($urandom); wreg_i = 1'($urandom); annul_i = ($urandom_range(0, 7) == 0);
            #2;
            chk("rand wdata", wdata_o, alu_model(aluop_i, alusel_i, reg1_i, reg2_i));
            chk("rand wreg", {31'd0, wreg_o}, {31'd0, wreg_i & ~annul_i});
            step();
        end
        set_nop();
        step();

        do_div("divu100_7", 0, 32'd100, 32'd7);
        set_nop();
        @(negedge clk);
        chk("divu whilo_one_cycle", {31'd0, whilo_o}, 0);
        step();
        do_div("div-7_2", 1, 32'hFFFF_FFF9, 32'd2);
        do_div("div7_-2", 1, 32'd7, 32'hFFFF_FFFE);
        do_div("div_by0", 1, 32'd1234, 32'd0);
        do_div("div_min_-1", 1, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++)
            do_div($sformatf("rdiv%0d", i), 1'($urandom), $urandom, $urandom >> $urandom_range(0, 31));
        set_nop();
        step();

        for (int k = 0; k < 2; k++) begin
            bit saw;
            aluop_i = DIVU_; reg1_i = 32'd1000; reg2_i = 32'd3; wreg_i = 1;
            repeat (10) step();
            if (k == 0) annul_i = 1; else rst = 1;
            #2;
            chk($sformatf("abort%0d stall", k), {31'd0, stallreq_o}, 0);
            chk($sformatf("abort%0d wreg", k), {31'd0, wreg_o}, 0);
            step();
            annul_i = 0; rst = 0;
            set_nop();
            saw = 0;
            repeat (40) begin
                @(negedge clk);
                if (whilo_o || stallreq_o) saw = 1;
                step();
            end
            chk($sformatf("abort%0d no_hilo", k), {31'd0, saw}, 0);
            do_div($sformatf("after_abort%0d", k), 0, 32'd9, 32'd3);
            set_nop();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline; consumes decoded operands from the id_ex register and drives ex_mem.
- Computes logic and shift results combinationally.
- Contains a multi-cycle radix-2 restoring divider (DIV/DIVU) that writes HI/LO and stalls the pipeline via ctrl.
- wd_o/wreg_o/wdata_o are also routed back to the decode stage for EX-stage forwarding.

Parameters:
DIV_CYCLES, 32, divider iteration count (one quotient bit per cycle); fixed to operand width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
aluop_i  input  8  operation subtype
alusel_i  input  3  operation class
reg1_i  input  32  source operand 1 (shift amount in [4:0] for shifts)
reg2_i  input  32  source operand 2
wd_i  input  5  destination GPR address
wreg_i  input  1  GPR write request
annul_i  input  1  flush: abort divider, treat current instruction as NOP
wd_o  output  5  destination GPR address to ex_mem
wreg_o  output  1  GPR write enable to ex_mem
wdata_o  output  32  GPR write data
whilo_o  output  1  HI/LO write enable
hi_o  output  32  HI value (remainder)
lo_o  output  32  LO value (quotient)
stallreq_o  output  1  request pipeline stall to ctrl

Behaviour:
- Encodings: alusel NOP=000, LOGIC=001, SHIFT=010. aluop AND=00100100, OR=00100101, XOR=00100110, NOR=00100111, SLL=01111100, SRL=00000010, SRA=00000011, DIV=00011010, DIVU=00011011, NOP=00000000.
- Reset (rst=1 at a clock edge): divider FSM -> IDLE, internal registers cleared. While rst=1 all outputs are 0.
- Logic: OR/AND/XOR/NOR on reg1_i and reg2_i. Unlisted aluop gives 0.
- Shift: SLL gives reg2_i<<reg1_i[4:0]. SRL is logical right. SRA is arithmetic right. Upper bits of reg1_i are ignored.
- wdata_o selects logic result for LOGIC, shift result for SHIFT, 0 otherwise.
- wd_o=wd_i and wreg_o=wreg_i, except annul_i=1 or divide op forces wreg_o=0.
- All non-divide paths have 0 cycles of latency (pure combinational through EX).
- Divider FSM states:
  - IDLE: on DIV/DIVU with annul_i=0:
    - if reg2_i=0 -> DIVZERO;
    - else latch |operands| (DIV: two's-complement negate negative operands; DIVU: raw), clear counter and partial remainder -> ON.
    - stallreq_o=1 in the issuing cycle.
  - DIVZERO: stallreq_o=1; result forced to 0; -> END.
  - ON: each cycle shift the partial remainder left 1, bringing in the next dividend MSB. If partial remainder >= divisor, subtract and set quotient bit=1, else quotient bit=0. Counter+1. After 32 iterations -> END. stallreq_o=1.
  - END: stallreq_o=0, whilo_o=1, hi_o=remainder, lo_o=quotient. -> IDLE at next edge unconditionally; ctrl advances the pipeline on that same edge.
- Signed fixup (DIV): quotient is negated when operand signs differ; remainder takes the sign of the dividend. Applied before END output.
- Timing: a DIV issued at cycle 0 holds stallreq_o for cycles 0..33 (IDLE + 32 ON + 1 settle into END). END occurs at cycle 34. Divide-by-zero: stall cycles 0..1, END at cycle 2.
- A DIV immediately following a DIV is picked up from IDLE with no extra bubble.
- whilo_o=0 and hi_o=lo_o=0 in every state except END.
- annul_i=1 in any state: FSM -> IDLE at next edge, stallreq_o=0 combinationally, whilo_o=0, wreg_o=0.
- rst during ON: FSM -> IDLE; no HI/LO write.
- id_ex holds its outputs stable while stallreq_o=1; operands are also latched internally, so later changes to reg1_i/reg2_i do not affect the result.

Test Plan:
- OR: reg1=0x0000_1100, reg2=0x0000_0020, wreg_i=1, wd=5 -> wdata_o=0x0000_1120, wreg_o=1, wd_o=5, stallreq_o=0, same cycle.
- SRA: reg1=4, reg2=0x8000_0000 -> wdata_o=0xF800_0000; SRL with same operands -> 0x0800_0000; reg1=0x24 -> shift by 4.
- DIVU 100/7: stallreq_o high 34 cycles; END gives lo_o=14, hi_o=2, whilo_o=1 for exactly one cycle; wreg_o=0 throughout.
- DIV -7/2: lo_o=0xFFFF_FFFD (-3), hi_o=0xFFFF_FFFF (-1); DIV 7/-2: lo_o=-3, hi_o=1.
- DIV by zero: stallreq_o high 2 cycles, END gives hi_o=lo_o=0, whilo_o=1.
- Abort: assert annul_i at ON cycle 10, or rst at cycle 10 -> stallreq_o drops, no whilo_o pulse; a following DIVU 9/3 completes normally with lo_o=3, hi_o=0.
